// File: rtl/manchester_pkg.sv
// rtl/manchester_pkg.sv - symbol constants and frame-state enum shared by the Manchester encoder and decoder
package manchester_pkg;

  localparam logic [7:0] PREAMBLE_PATTERN_DEFAULT = 8'hAA;
  localparam logic [7:0] START_WORD_DEFAULT       = 8'hD5;
  localparam logic [7:0] ESCAPE_SYMBOL_DEFAULT    = 8'hE5;
  localparam logic [7:0] REPLACE_SYMBOL_DEFAULT   = 8'hF5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_START,
    ST_PAYLOAD,
    ST_GAP
  } frame_state_t;

  // A payload byte that would look like a start word or an escape must be escaped
  function automatic logic needs_escape(input logic [7:0] data,
                                        input logic [7:0] escape_symbol,
                                        input logic [7:0] start_word);
    return (data == escape_symbol) || (data == start_word);
  endfunction

endpackage

// File: rtl/manchester_bit_serializer.sv
// rtl/manchester_bit_serializer.sv - shifts one 8-bit symbol MSB-first onto a Manchester-coded line
module manchester_bit_serializer #(
  parameter int HALF_BIT_CYCLES = 1
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       load,
  input  logic [7:0] symbol,
  output logic       line,
  output logic       active,
  output logic       symbol_done
);

  localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT_CYCLES - 1);

  logic [7:0]    shift;
  logic [2:0]    bits_left;
  logic          second_half;
  logic [CW-1:0] half_cnt;
  logic          half_end;

  assign half_end    = (half_cnt == HALF_LAST);
  // Final cycle of the second half of bit 0; the next symbol may be loaded on this edge
  assign symbol_done = active && second_half && half_end && (bits_left == 3'd0);

  // Half-bit timing, shifter and registered line output (first half ~bit, second half bit)
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shift       <= '0;
      bits_left   <= '0;
      second_half <= 1'b0;
      half_cnt    <= '0;
      active      <= 1'b0;
      line        <= 1'b0;
    end else if (load) begin
      shift       <= symbol;
      bits_left   <= 3'd7;
      second_half <= 1'b0;
      half_cnt    <= '0;
      active      <= 1'b1;
      line        <= ~symbol[7];
    end else if (active) begin
      if (!half_end) begin
        half_cnt <= half_cnt + 1'b1;
      end else begin
        half_cnt <= '0;
        if (!second_half) begin
          second_half <= 1'b1;
          line        <= shift[7];
        end else if (bits_left == 3'd0) begin
          second_half <= 1'b0;
          active      <= 1'b0;
          line        <= 1'b0;
        end else begin
          bits_left   <= bits_left - 3'd1;
          shift       <= {shift[6:0], 1'b0};
          second_half <= 1'b0;
          line        <= ~shift[6];
        end
      end
    end
  end

endmodule

// File: rtl/manchester_encoder.sv
// rtl/manchester_encoder.sv - frame builder and Manchester line coder (optional: MANCHESTER_ENC_STUFFING_EN)
module manchester_encoder
  import manchester_pkg::*;
#(
  parameter int         FRAME_SIZE       = 64,
  parameter int         PREAMBLE_LEN     = 2,
  parameter int         HALF_BIT_CYCLES  = 1,
  parameter int         GAP_BITS         = 4,
  parameter logic [7:0] PREAMBLE_PATTERN = manchester_pkg::PREAMBLE_PATTERN_DEFAULT,
  parameter logic [7:0] START_WORD       = manchester_pkg::START_WORD_DEFAULT,
  parameter logic [7:0] ESCAPE_SYMBOL    = manchester_pkg::ESCAPE_SYMBOL_DEFAULT,
  parameter logic [7:0] REPLACE_SYMBOL   = manchester_pkg::REPLACE_SYMBOL_DEFAULT
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       manchester_out,
  output logic       busy,
  output logic       underrun
);

  localparam int BW         = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int PW         = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam int GAP_CYCLES = GAP_BITS * 2 * HALF_BIT_CYCLES;
  localparam int GW         = $clog2(GAP_CYCLES);

  localparam logic [BW-1:0] BYTE_LAST = BW'(FRAME_SIZE - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  frame_state_t  state, state_nxt;
  logic [PW-1:0] pre_cnt, pre_cnt_nxt;
  logic [BW-1:0] byte_cnt, byte_cnt_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic          payload_done, payload_done_nxt;
  logic          underrun_nxt;

  logic          hold_valid;
  logic [7:0]    hold_data;
  logic          ready_en;
  logic          accept;
  logic          release_hold;
  logic          count_byte;

  logic          ser_load;
  logic [7:0]    ser_symbol;
  logic          ser_active;
  logic          ser_done;
  logic          ser_ready;

`ifdef MANCHESTER_ENC_STUFFING_EN
  logic          esc_pending, esc_pending_nxt;
`else
  // Symbol constants stay on the interface so both builds share one parameter list
  logic          unused_symbols;
  assign unused_symbols = ^{ESCAPE_SYMBOL, REPLACE_SYMBOL};
`endif

  assign s_axis_tready = ready_en && !hold_valid;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign busy          = (state != ST_IDLE);
  assign ser_ready     = !ser_active || ser_done;

  // tready stays low through reset and rises on the first edge after release
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Single-byte holding register; a new accept wins over a same-cycle release
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= s_axis_tdata;
    end else if (release_hold) begin
      hold_valid <= 1'b0;
    end
  end

  // Frame FSM state and counters
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= ST_IDLE;
      pre_cnt      <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      payload_done <= 1'b0;
      underrun     <= 1'b0;
`ifdef MANCHESTER_ENC_STUFFING_EN
      esc_pending  <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      pre_cnt      <= pre_cnt_nxt;
      byte_cnt     <= byte_cnt_nxt;
      gap_cnt      <= gap_cnt_nxt;
      payload_done <= payload_done_nxt;
      underrun     <= underrun_nxt;
`ifdef MANCHESTER_ENC_STUFFING_EN
      esc_pending  <= esc_pending_nxt;
`endif
    end
  end

  // Next state, symbol selection and serializer load; symbols are fetched on the
  // serializer's last cycle so they run back-to-back
  always_comb begin
    state_nxt        = state;
    pre_cnt_nxt      = pre_cnt;
    byte_cnt_nxt     = byte_cnt;
    gap_cnt_nxt      = gap_cnt;
    payload_done_nxt = payload_done;
    underrun_nxt     = 1'b0;
    ser_load         = 1'b0;
    ser_symbol       = '0;
    release_hold     = 1'b0;
    count_byte       = 1'b0;
`ifdef MANCHESTER_ENC_STUFFING_EN
    esc_pending_nxt  = esc_pending;
`endif

    case (state)
      ST_IDLE: begin
        if (hold_valid) begin
          state_nxt   = ST_PREAMBLE;
          pre_cnt_nxt = '0;
        end
      end

      ST_PREAMBLE: begin
        if (ser_ready) begin
          ser_load   = 1'b1;
          ser_symbol = PREAMBLE_PATTERN;
          if (pre_cnt == PRE_LAST) state_nxt = ST_START;
          else                     pre_cnt_nxt = pre_cnt + 1'b1;
        end
      end

      ST_START: begin
        if (ser_ready) begin
          ser_load         = 1'b1;
          ser_symbol       = START_WORD;
          state_nxt        = ST_PAYLOAD;
          byte_cnt_nxt     = '0;
          payload_done_nxt = 1'b0;
        end
      end

      ST_PAYLOAD: begin
        if (ser_ready) begin
          if (payload_done) begin
            // Last payload symbol has just finished; the line is low from here
            state_nxt   = ST_GAP;
            gap_cnt_nxt = '0;
          end
`ifdef MANCHESTER_ENC_STUFFING_EN
          else if (esc_pending) begin
            ser_load        = 1'b1;
            ser_symbol      = (hold_data == ESCAPE_SYMBOL) ? ESCAPE_SYMBOL : REPLACE_SYMBOL;
            release_hold    = 1'b1;
            esc_pending_nxt = 1'b0;
            count_byte      = 1'b1;
          end else if (hold_valid && needs_escape(hold_data, ESCAPE_SYMBOL, START_WORD)) begin
            ser_load        = 1'b1;
            ser_symbol      = ESCAPE_SYMBOL;
            esc_pending_nxt = 1'b1;
          end
`endif
          else if (hold_valid) begin
            ser_load     = 1'b1;
            ser_symbol   = hold_data;
            release_hold = 1'b1;
            count_byte   = 1'b1;
          end else begin
            ser_load     = 1'b1;
            ser_symbol   = 8'h00;
            underrun_nxt = 1'b1;
            count_byte   = 1'b1;
          end
        end
      end

      ST_GAP: begin
        gap_cnt_nxt = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) begin
          if (hold_valid) begin
            // Chain straight into the next frame so the gap is exactly GAP_CYCLES long
            ser_load    = 1'b1;
            ser_symbol  = PREAMBLE_PATTERN;
            pre_cnt_nxt = PW'(1);
            state_nxt   = (PREAMBLE_LEN > 1) ? ST_PREAMBLE : ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    if (count_byte) begin
      if (byte_cnt == BYTE_LAST) payload_done_nxt = 1'b1;
      else                       byte_cnt_nxt     = byte_cnt + 1'b1;
    end
  end

  manchester_bit_serializer #(
    .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
  ) u_serializer (
    .aclk        (aclk),
    .areset      (areset),
    .load        (ser_load),
    .symbol      (ser_symbol),
    .line        (manchester_out),
    .active      (ser_active),
    .symbol_done (ser_done)
  );

endmodule

// File: tb/tb_manchester_encoder.sv
// tb/tb_manchester_encoder.sv - self-checking bench for manchester_encoder (honours MANCHESTER_ENC_STUFFING_EN)
module tb_manchester_encoder;

  localparam int FS      = 4;
  localparam int PL      = 2;
  localparam int HB      = 1;
  localparam int GB      = 4;
  localparam int GAP_CYC = GB * 2 * HB;
  localparam int TRACE_N = 4096;
`ifdef MANCHESTER_ENC_STUFFING_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       line;
  logic       busy;
  logic       und;

  always #5 aclk = ~aclk;

  manchester_encoder #(
    .FRAME_SIZE      (FS),
    .PREAMBLE_LEN    (PL),
    .HALF_BIT_CYCLES (HB),
    .GAP_BITS        (GB)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axis_tdata   (tdata),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .manchester_out (line),
    .busy           (busy),
    .underrun       (und)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic       trace_line [0:TRACE_N-1];
  logic       trace_busy [0:TRACE_N-1];
  logic       trace_und  [0:TRACE_N-1];
  logic [7:0] src_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] all_q[$];
  int         accept_cyc[$];
  bit         feed_en;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One step per cycle: sample outputs at the falling edge, then present the next source byte
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      if (cyc < TRACE_N) begin
        trace_line[cyc] = line;
        trace_busy[cyc] = busy;
        trace_und[cyc]  = und;
      end
      if (feed_en && src_q.size() > 0) begin
        tvalid = 1'b1;
        tdata  = src_q[0];
      end else begin
        tvalid = 1'b0;
        tdata  = 8'($urandom);
      end
      if (tvalid && tready) begin
        void'(src_q.pop_front());
        accept_cyc.push_back(cyc);
      end
      cyc++;
    end
  endtask

  // Expected line symbols for one frame: preamble, start word, stuffed payload, zeros for missing bytes
  task automatic build_exp();
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < PL; i++) exp_q.push_back(8'hAA);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < FS; i++) begin
      b = (i < pay_q.size()) ? pay_q[i] : 8'h00;
      if (STUFF && b == 8'hD5) begin
        exp_q.push_back(8'hE5);
        exp_q.push_back(8'hF5);
      end else if (STUFF && b == 8'hE5) begin
        exp_q.push_back(8'hE5);
        exp_q.push_back(8'hE5);
      end else begin
        exp_q.push_back(b);
      end
    end
  endtask

  // Bit 8 = every bit had a mid-bit transition; bits 7:0 = second-half values
  function automatic logic [8:0] decode_at(input int pos);
    logic [8:0] r;
    r = 9'h100;
    for (int k = 0; k < 8; k++) begin
      if (trace_line[pos + 2*k] === trace_line[pos + 2*k + 1]) r[8] = 1'b0;
      r[7-k] = trace_line[pos + 2*k + 1];
    end
    return r;
  endfunction

  function automatic int count_und(input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i < b; i++) n += int'(trace_und[i]);
    return n;
  endfunction

  task automatic get_start(input string tag, output int start);
    check({tag, "_accepted"}, 32'(accept_cyc.size() > 0), 32'd1);
    start = (accept_cyc.size() > 0) ? accept_cyc[0] + 3 : 8;
  endtask

  task automatic check_frame(input int start, input string tag, input bit last);
    int end_c;
    int highs;
    for (int s = 0; s < exp_q.size(); s++)
      check($sformatf("%s_sym%0d", tag, s), 32'(decode_at(start + 16*s)), {23'd0, 1'b1, exp_q[s]});
    end_c = start + 16 * exp_q.size();
    highs = 0;
    for (int g = 0; g < GAP_CYC; g++) highs += int'(trace_line[end_c + g]);
    check({tag, "_gap_low"}, 32'(highs), 32'd0);
    check({tag, "_gap_busy"}, 32'(trace_busy[end_c + GAP_CYC - 1]), 32'd1);
    if (last) check({tag, "_idle_after_gap"}, 32'(trace_busy[end_c + GAP_CYC]), 32'd0);
  endtask

  // Receive-side view: de-stuff the decoded payload symbols and compare with what was sent
  task automatic check_destuff(input int start, input string tag);
    int         idx;
    logic [7:0] b;
    logic [7:0] b2;
    idx = start + 16 * (PL + 1);
    for (int n = 0; n < FS; n++) begin
      b = decode_at(idx)[7:0];
      idx += 16;
      if (STUFF && b == 8'hE5) begin
        b2  = decode_at(idx)[7:0];
        idx += 16;
        b   = (b2 == 8'hF5) ? 8'hD5 : 8'hE5;
      end
      check($sformatf("%s_rx%0d", tag, n), 32'(b), 32'(pay_q[n]));
    end
  endtask

  initial begin
    int start;
    int start2;
    int n;
    areset  = 1'b1;
    tvalid  = 1'b0;
    tdata   = 8'h00;
    feed_en = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_line", 32'(line), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(und), 32'd0);
    check("rst_tready", 32'(tready), 32'd0);
    areset = 1'b0;
    #1 check("tready_before_edge", 32'(tready), 32'd0);
    run(1);
    check("tready_after_edge", 32'(tready), 32'd1);

    // Basic frame
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    src_q = pay_q;
    accept_cyc.delete();
    feed_en = 1'b1;
    run(150);
    get_start("basic", start);
    build_exp();
    check_frame(start, "basic", 1'b1);
    check("basic_accepts", 32'(accept_cyc.size()), 32'd4);
    check("basic_busy_lead", 32'(trace_busy[start-1]), 32'd1);
    check("basic_idle_lead", 32'(trace_busy[start-2]), 32'd0);
    check("basic_underrun", 32'(count_und(start - 2, start + 16*exp_q.size() + GAP_CYC)), 32'd0);

    // Stuffing of start word and escape inside the payload
    pay_q = '{8'hD5, 8'hE5, 8'h10, 8'h20};
    src_q = pay_q;
    accept_cyc.delete();
    run(180);
    get_start("stuff", start);
    build_exp();
    check_frame(start, "stuff", 1'b1);
    check_destuff(start, "stuff");

    // Underrun: only the first byte is ever offered
    pay_q = '{8'h01};
    src_q = pay_q;
    accept_cyc.delete();
    run(150);
    get_start("underrun", start);
    build_exp();
    check_frame(start, "underrun", 1'b1);
    check("underrun_pulses", 32'(count_und(start - 2, start + 16*exp_q.size() + GAP_CYC + 1)), 32'd3);

    // Back-to-back frames with the source always valid
    src_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    pay_q = '{8'h11, 8'h12, 8'h13, 8'h14};
    accept_cyc.delete();
    run(280);
    get_start("b2b", start);
    check("b2b_accepts", 32'(accept_cyc.size()), 32'd8);
    build_exp();
    check_frame(start, "b2b_f1", 1'b0);
    start2 = start + 16*exp_q.size() + GAP_CYC;
    pay_q = '{8'h15, 8'h16, 8'h17, 8'h18};
    build_exp();
    check_frame(start2, "b2b_f2", 1'b1);

    // Reset in the middle of the second payload byte
    pay_q = '{8'h21, 8'h22, 8'h23, 8'h24};
    src_q = pay_q;
    accept_cyc.delete();
    run(5);
    get_start("midrst", start);
    n = start + 16*(PL + 2) + 5 - cyc + 1;
    if (n > 0) run(n);
    #2 areset = 1'b1;
    #1;
    check("midrst_line", 32'(line), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_underrun", 32'(und), 32'd0);
    src_q.delete();
    tvalid = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    pay_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    src_q = pay_q;
    accept_cyc.delete();
    run(150);
    get_start("post_rst", start);
    build_exp();
    check_frame(start, "post_rst", 1'b1);
    check("post_rst_underrun", 32'(count_und(start - 2, start + 16*exp_q.size())), 32'd0);

    // Random loopback over three chained frames, biased towards D5/E5
    all_q.delete();
    for (int i = 0; i < 3*FS; i++) begin
      case ($urandom_range(0, 3))
        0:       all_q.push_back(8'hD5);
        1:       all_q.push_back(8'hE5);
        default: all_q.push_back(8'($urandom));
      endcase
    end
    src_q = all_q;
    accept_cyc.delete();
    run(620);
    get_start("lb", start);
    for (int f = 0; f < 3; f++) begin
      pay_q.delete();
      for (int i = 0; i < FS; i++) pay_q.push_back(all_q[f*FS + i]);
      build_exp();
      check_frame(start, $sformatf("lb%0d", f), f == 2);
      check_destuff(start, $sformatf("lb%0d", f));
      start += 16*exp_q.size() + GAP_CYC;
    end
    check("lb_underrun", 32'(count_und(accept_cyc.size() > 0 ? accept_cyc[0] : 0, start)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
